// File: rtl/nash_lif_core.sv
// ============================================================================
// Module   : nash_lif_core
// Purpose  : Leaky integrate-and-fire neuron engine, one neuron per clock sweep
// Revision : 1.0
// ============================================================================
`default_nettype none

module nash_lif_core #(
  parameter int N_NEURONS = 4,
  parameter int IDX_W     = 2,
  parameter int V_W       = 16,
  parameter int REFR_W    = 4
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_aresetn,
  input  logic                    cfg_enable,
  input  logic signed [V_W-1:0]   cfg_threshold,
  input  logic signed [V_W-1:0]   cfg_v_reset,
  input  logic        [3:0]       cfg_leak_shift,
  input  logic        [REFR_W-1:0] cfg_refract,
  input  logic                    clr_overrun,
  input  logic                    tick,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic        [IDX_W-1:0] in_idx,
  input  logic signed [V_W-1:0]   in_weight,
  output logic                    spike_valid,
  input  logic                    spike_ready,
  output logic        [IDX_W-1:0] spike_idx,
  output logic                    busy,
  output logic                    overrun,
  output logic        [31:0]      spike_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0]      c_last_idx = IDX_W'(N_NEURONS - 1);
  localparam logic signed [V_W-1:0] c_v_max    = {1'b0, {(V_W-1){1'b1}}};
  localparam logic signed [V_W-1:0] c_v_min    = {1'b1, {(V_W-1){1'b0}}};

  state_t                  r_state;
  logic [IDX_W-1:0]        r_ptr;
  logic signed [V_W-1:0]   r_v    [N_NEURONS];
  logic [REFR_W-1:0]       r_refr [N_NEURONS];
  logic                    r_in_ready;
  logic                    r_spike_valid;
  logic [IDX_W-1:0]        r_spike_idx;
  logic                    r_overrun;
  logic [31:0]             r_spike_count;

  logic                    w_accept;
  logic signed [V_W:0]     w_sum;
  logic signed [V_W-1:0]   w_sat;
  logic signed [V_W-1:0]   w_cur_v;
  logic signed [V_W-1:0]   w_vl;
  logic                    w_fire;
  logic                    w_last;

  assign w_accept = in_valid && r_in_ready;
  assign w_sum    = {r_v[in_idx][V_W-1], r_v[in_idx]} + {in_weight[V_W-1], in_weight};

  // Sign disagreement between the guard bit and MSB flags overflow.
  always_comb begin
    w_sat = w_sum[V_W-1:0];
    if (w_sum[V_W] != w_sum[V_W-1]) begin
      w_sat = w_sum[V_W] ? c_v_min : c_v_max;
    end
  end

  assign w_cur_v = r_v[r_ptr];
  assign w_vl    = (cfg_leak_shift == 4'd0) ? w_cur_v : (w_cur_v - (w_cur_v >>> cfg_leak_shift));
  assign w_fire  = (w_vl >= cfg_threshold);
  assign w_last  = (r_ptr == c_last_idx);

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_in_ready    <= 1'b0;
      r_spike_valid <= 1'b0;
      r_spike_idx   <= '0;
      r_overrun     <= 1'b0;
      r_spike_count <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        r_v[i]    <= '0;
        r_refr[i] <= '0;
      end
    end else begin
      r_in_ready <= 1'b0;

      if (w_accept && (r_refr[in_idx] == '0)) begin
        r_v[in_idx] <= w_sat;
      end

      if (tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (tick && cfg_enable) begin
            r_state <= S_SWEEP;
            r_ptr   <= '0;
          end else begin
            r_in_ready <= cfg_enable;
          end
        end

        S_SWEEP: begin
          if ((r_refr[r_ptr] == '0) && w_fire) begin
            r_v[r_ptr]    <= cfg_v_reset;
            r_refr[r_ptr] <= cfg_refract;
            r_spike_valid <= 1'b1;
            r_spike_idx   <= r_ptr;
            r_state       <= S_EMIT;
          end else begin
            if (r_refr[r_ptr] != '0) begin
              r_refr[r_ptr] <= r_refr[r_ptr] - REFR_W'(1);
            end else begin
              r_v[r_ptr] <= w_vl;
            end
            if (w_last) begin
              r_state    <= S_IDLE;
              r_in_ready <= cfg_enable;
            end else begin
              r_ptr <= r_ptr + IDX_W'(1);
            end
          end
        end

        S_EMIT: begin
          if (spike_ready) begin
            r_spike_valid <= 1'b0;
            r_spike_count <= r_spike_count + 32'd1;
            if (w_last) begin
              r_state    <= S_IDLE;
              r_in_ready <= cfg_enable;
            end else begin
              r_state <= S_SWEEP;
              r_ptr   <= r_ptr + IDX_W'(1);
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign spike_valid = r_spike_valid;
  assign spike_idx   = r_spike_idx;
  assign busy        = (r_state != S_IDLE);
  assign overrun     = r_overrun;
  assign spike_count = r_spike_count;

endmodule

`default_nettype wire
